// File: rtl/board_serializer_if.sv
// board_serializer_if
//   Bundle of the solver-side capture inputs and the uart_tx-side byte
//   handshake used by board_serializer.
//   slave  : the serializer (consumes valid_in/solution/m/n/transmit_done,
//            produces send/byte_out/busy/done)
//   master : the environment driving the serializer
//   Signals:
//     valid_in      start pulse, capture solution/m/n
//     solution      cell bitmap, cell (r,c) at bit r*MAX_COLS+c
//     m, n          active row / column counts
//     transmit_done uart_tx finished the current byte
//     send          one-cycle strobe, byte_out valid
//     byte_out      byte to transmit
//     busy          frame in progress
//     done          one-cycle pulse after the last byte completes
interface board_serializer_if #(
   parameter int MAX_ROWS = 11,
   parameter int MAX_COLS = 11
);
   logic                              valid_in;
   logic [MAX_ROWS*MAX_COLS-1:0]      solution;
   logic [$clog2(MAX_ROWS)-1:0]       m;
   logic [$clog2(MAX_COLS)-1:0]       n;
   logic                              transmit_done;
   logic                              send;
   logic [7:0]                        byte_out;
   logic                              busy;
   logic                              done;

   modport master (
      output valid_in, solution, m, n, transmit_done,
      input  send, byte_out, busy, done
   );

   modport slave (
      input  valid_in, solution, m, n, transmit_done,
      output send, byte_out, busy, done
   );
endinterface

// File: rtl/board_serializer.sv
// board_serializer
//   Captures a solved nonogram board on a start pulse and emits one framed
//   byte stream to uart_tx: header {m,n}, packed row bytes (cell c of a row
//   at bit c%8 of byte c/8, unused bits zero), then the XOR of all
//   preceding bytes. One byte per send / transmit_done handshake.
//   Ports:
//     clk  50 MHz system clock
//     rst  synchronous, active-high reset
//     bus  board_serializer_if.slave (capture inputs + uart handshake)
module board_serializer #(
   parameter int MAX_ROWS = 11,
   parameter int MAX_COLS = 11
) (
   input  logic                 clk,
   input  logic                 rst,
   board_serializer_if.slave    bus
);
   localparam int CELLS = MAX_ROWS * MAX_COLS;
   localparam int IW    = $clog2(CELLS);
   localparam int RW    = $clog2(MAX_ROWS + 1);
   localparam int CW    = $clog2(MAX_COLS + 1);
   localparam int BMAX  = (MAX_COLS + 7) / 8;
   localparam int BW    = $clog2(BMAX + 1);

   typedef enum logic [2:0] {IDLE, HDR, WAIT, ROW, CSUM, FIN} state_t;

   state_t            state_q, state_d;
   logic [CELLS-1:0]  sol_q;
   logic [RW-1:0]     m_q, row_q;
   logic [CW-1:0]     n_q;
   logic [BW-1:0]     nb_q, col_byte_q;
   logic [7:0]        xor_q, byte_q;
   logic              csum_sent_q;

   logic [RW-1:0]     m_sat;
   logic [CW-1:0]     n_sat;
   logic [7:0]        hdr;
   logic [7:0]        row_byte;
   logic              rows_left;

   assign m_sat     = (32'(bus.m) > MAX_ROWS) ? RW'(MAX_ROWS) : RW'(bus.m);
   assign n_sat     = (32'(bus.n) > MAX_COLS) ? CW'(MAX_COLS) : CW'(bus.n);
   assign hdr       = {4'(m_sat), 4'(n_sat)};
   // nb_q == 0 (n == 0) means no row bytes at all, whatever m is.
   assign rows_left = (nb_q != '0) && (row_q < m_q);

   // Byte at (row_q, col_byte_q) of the captured board, masked past n.
   always_comb begin
      int unsigned c;
      int unsigned idx;
      c        = 0;
      idx      = 0;
      row_byte = '0;
      for (int unsigned j = 0; j < 8; j++) begin
         c   = 32'(col_byte_q) * 8 + j;
         idx = 32'(row_q) * MAX_COLS + c;
         if ((c < 32'(n_q)) && (idx < CELLS))
            row_byte[j] = sol_q[IW'(idx)];
      end
   end

   always_ff @(posedge clk) begin
      if (rst) state_q <= IDLE;
      else     state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: if (bus.valid_in) state_d = HDR;
         HDR,
         ROW,
         CSUM: state_d = WAIT;
         WAIT: begin
            if (bus.transmit_done) begin
               if (csum_sent_q)    state_d = FIN;
               else if (rows_left) state_d = ROW;
               else                state_d = CSUM;
            end
         end
         FIN:     state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // The byte for each strobe state is registered on the edge that enters
   // it, so byte_out is already valid in the cycle send is high and then
   // simply holds until the next load.
   always_ff @(posedge clk) begin
      if (rst) begin
         sol_q       <= '0;
         m_q         <= '0;
         n_q         <= '0;
         nb_q        <= '0;
         row_q       <= '0;
         col_byte_q  <= '0;
         xor_q       <= '0;
         byte_q      <= '0;
         csum_sent_q <= 1'b0;
      end else begin
         case (state_q)
            IDLE: begin
               if (bus.valid_in) begin
                  sol_q       <= bus.solution;
                  m_q         <= m_sat;
                  n_q         <= n_sat;
                  nb_q        <= BW'((32'(n_sat) + 32'd7) >> 3);
                  row_q       <= '0;
                  col_byte_q  <= '0;
                  csum_sent_q <= 1'b0;
                  byte_q      <= hdr;
                  xor_q       <= hdr;
               end
            end
            WAIT: begin
               if (bus.transmit_done && !csum_sent_q) begin
                  if (rows_left) begin
                     byte_q <= row_byte;
                     xor_q  <= xor_q ^ row_byte;
                     if (col_byte_q + BW'(1) == nb_q) begin
                        col_byte_q <= '0;
                        row_q      <= row_q + RW'(1);
                     end else begin
                        col_byte_q <= col_byte_q + BW'(1);
                     end
                  end else begin
                     byte_q      <= xor_q;
                     // running XOR folded with the checksum itself
                     xor_q       <= '0;
                     csum_sent_q <= 1'b1;
                  end
               end
            end
            default: ;
         endcase
      end
   end

   always_comb begin
      bus.send     = (state_q == HDR) || (state_q == ROW) || (state_q == CSUM);
      bus.busy     = (state_q == HDR) || (state_q == ROW) || (state_q == CSUM)
                     || (state_q == WAIT);
      bus.done     = (state_q == FIN);
      bus.byte_out = byte_q;
   end
endmodule

// File: tb/tb_board_serializer.sv
// tb_board_serializer
//   Self-checking bench for board_serializer. A frame model builds the
//   expected byte list straight from the frame rules; each frame is driven
//   through the handshake with random transmit_done delays, and timing of
//   send/busy/done is checked against the handshake cycle by cycle.
module tb_board_serializer;
   localparam int MR = 11;
   localparam int MC = 11;

   logic clk;
   logic rst;

   board_serializer_if #(.MAX_ROWS(MR), .MAX_COLS(MC)) bus ();

   board_serializer #(.MAX_ROWS(MR), .MAX_COLS(MC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #10 clk = ~clk;

   int unsigned checks = 0;
   int unsigned errors = 0;
   logic [7:0]  exp_q[$];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not complete");
      $fatal(1, "watchdog expired");
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [MR*MC-1:0] rand_board();
      logic [127:0] t;
      t = {$urandom, $urandom, $urandom, $urandom};
      return t[MR*MC-1:0];
   endfunction

   // Expected frame from the frame rules: header, m*B row bytes, XOR.
   task automatic model_frame(input logic [MR*MC-1:0] sol, input int unsigned mr, input int unsigned nr);
      int unsigned ms, ns, nbytes, c;
      logic [7:0]  b, x;
      ms = (mr > MR) ? MR : mr;
      ns = (nr > MC) ? MC : nr;
      exp_q.delete();
      exp_q.push_back(8'(ms * 16 + ns));
      nbytes = (ns + 7) / 8;
      for (int unsigned r = 0; r < ms; r++)
         for (int unsigned k = 0; k < nbytes; k++) begin
            b = 8'h00;
            for (int unsigned bt = 0; bt < 8; bt++) begin
               c = 8 * k + bt;
               if (c < ns && sol[r * MC + c]) b[bt] = 1'b1;
            end
            exp_q.push_back(b);
         end
      x = 8'h00;
      foreach (exp_q[i]) x = x ^ exp_q[i];
      exp_q.push_back(x);
   endtask

   // Called at a negedge in IDLE; returns at the negedge of the header strobe.
   task automatic start_frame(input logic [MR*MC-1:0] sol, input int unsigned mr, input int unsigned nr);
      bus.solution = sol;
      bus.m        = 4'(mr);
      bus.n        = 4'(nr);
      bus.valid_in = 1'b1;
      model_frame(sol, mr, nr);
      @(negedge clk);
      bus.valid_in = 1'b0;
   endtask

   // Walks exp_q through the handshake. abort_at >= 0 resets the DUT in the
   // wait after that byte. Returns at the negedge two cycles after the last
   // transmit_done (earliest cycle a new valid_in is accepted).
   task automatic run_frame(input int abort_at, input bit disturb);
      int unsigned d;
      bit          got;
      for (int i = 0; i < exp_q.size(); i++) begin
         check("send_strobe", bus.send, 1);
         if (bus.send !== 1'b1) begin
            got = 1'b0;
            for (int w = 0; w < 30 && !got; w++) begin
               @(negedge clk);
               if (bus.send === 1'b1) got = 1'b1;
            end
            check("send_timeout", 32'(got), 1);
            if (!got) return;
         end
         check($sformatf("byte_%0d", i), bus.byte_out, exp_q[i]);
         check("busy_strobe", bus.busy, 1);
         check("done_strobe", bus.done, 0);
         // transmit_done coinciding with send must be ignored
         if ($urandom_range(0, 1) == 1) bus.transmit_done = 1'b1;
         @(negedge clk);
         bus.transmit_done = 1'b0;
         check("send_one_cycle", bus.send, 0);
         check("byte_hold", bus.byte_out, exp_q[i]);
         check("busy_wait", bus.busy, 1);
         if (abort_at == i) begin
            rst               = 1'b1;
            bus.transmit_done = 1'b1;
            @(negedge clk);
            rst               = 1'b0;
            bus.transmit_done = 1'b0;
            check("abort_send", bus.send, 0);
            check("abort_busy", bus.busy, 0);
            check("abort_byte", bus.byte_out, 0);
            check("abort_done", bus.done, 0);
            repeat (6) begin
               @(negedge clk);
               check("abort_quiet_send", bus.send, 0);
               check("abort_quiet_done", bus.done, 0);
            end
            return;
         end
         if (disturb && i == 2) begin
            bus.valid_in = 1'b1;
            bus.solution = rand_board();
            bus.m        = 4'($urandom);
            bus.n        = 4'($urandom);
            @(negedge clk);
            bus.valid_in = 1'b0;
            check("disturb_send", bus.send, 0);
         end
         d = $urandom_range(0, 3);
         repeat (d) begin
            @(negedge clk);
            check("wait_no_send", bus.send, 0);
         end
         bus.transmit_done = 1'b1;
         @(negedge clk);
         bus.transmit_done = 1'b0;
      end
      check("done_pulse", bus.done, 1);
      check("busy_fall", bus.busy, 0);
      check("send_at_done", bus.send, 0);
      @(negedge clk);
      check("done_one_cycle", bus.done, 0);
      check("busy_idle", bus.busy, 0);
   endtask

   initial begin
      logic [MR*MC-1:0] board;

      rst               = 1'b1;
      bus.valid_in      = 1'b0;
      bus.solution      = '0;
      bus.m             = '0;
      bus.n             = '0;
      bus.transmit_done = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_send", bus.send, 0);
      check("rst_byte", bus.byte_out, 0);
      check("rst_busy", bus.busy, 0);
      check("rst_done", bus.done, 0);
      rst = 1'b0;
      @(negedge clk);
      check("idle_send", bus.send, 0);

      // 11x11 all zeros
      start_frame('0, 11, 11);
      check("zeros_len", exp_q.size(), 24);
      run_frame(-1, 1'b0);

      // 11x11 all ones, started at the earliest accepted cycle
      start_frame('1, 11, 11);
      run_frame(-1, 1'b0);

      // 3x5 diagonal, fixed expected bytes
      board = '0;
      for (int r = 0; r < 3; r++) board[r * MC + r] = 1'b1;
      start_frame(board, 3, 5);
      exp_q = '{8'h35, 8'h01, 8'h02, 8'h04, 8'h32};
      run_frame(-1, 1'b0);

      // empty board: header + checksum
      start_frame(rand_board(), 0, 0);
      exp_q = '{8'h00, 8'h00};
      run_frame(-1, 1'b0);

      // mid-frame valid_in and solution change ignored
      start_frame(rand_board(), 11, 11);
      run_frame(-1, 1'b1);

      // spurious transmit_done in IDLE
      bus.transmit_done = 1'b1;
      @(negedge clk);
      bus.transmit_done = 1'b0;
      check("idle_td_send", bus.send, 0);
      @(negedge clk);
      check("idle_td_send2", bus.send, 0);
      check("idle_td_busy", bus.busy, 0);

      // reset after the 5th byte, then a full fresh frame
      start_frame(rand_board(), 11, 11);
      run_frame(4, 1'b0);
      start_frame(rand_board(), 11, 11);
      check("fresh_len", exp_q.size(), 24);
      run_frame(-1, 1'b0);

      // random dimensions, including values above the maximum
      for (int f = 0; f < 8; f++) begin
         start_frame(rand_board(), $urandom_range(0, 15), $urandom_range(0, 15));
         run_frame(-1, 1'b0);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
